// File: rtl/vector_adder_ctrl_pkg.sv
// Shared vector-engine definitions: controller state encoding, default
// datapath widths and the adder op-config payload layout.
package vector_adder_ctrl_pkg;

  localparam int unsigned VEC_ADDR_W = 13;
  localparam int unsigned VEC_LEN_W  = 13;
  localparam int unsigned VEC_CFG_W  = 41;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Adder op config: scale [30:21], bias [20:5], shift [4:0]; upper bits reserved.
  typedef struct packed {
    logic [VEC_CFG_W-32:0] rsvd;
    logic [9:0]            scale;
    logic [15:0]           bias;
    logic [4:0]            shift;
  } op_cfg_t;

endpackage

// File: rtl/vec_issue_pipe.sv
// DEPTH-deep valid + payload delay line matching the buffer read latency.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_vld, in_data  entry launched this cycle
//   out_vld, out_data entry emerging DEPTH cycles later
module vec_issue_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     data_q [DEPTH];

  // Shift register; reset drops every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      data_q[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/vector_adder_ctrl.sv
// Vector-adder sequencer: accepts one command, loads the adder config,
// streams operand-row reads from the shared buffer, tags each row with its
// result address, pulses in_finish after the last row and counts results.
// Optional build macro: VEC_ADD_CTRL_TIMEOUT_EN adds a DRAIN watchdog.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy, cmd_src/dst/len/cfg  command handshake and payload
//   rd_req, rd_gnt, rd_addr          buffer read arbiter interface
//   op_cfg_vld, op_cfg               adder config load
//   in_data_vld, in_data_addr, in_finish  adder input strobes
//   out_data_vld, out_finish         adder result strobes
//   busy, done, err                  status
module vector_adder_ctrl
  import vector_adder_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = VEC_ADDR_W,
  parameter int unsigned LEN_W  = VEC_LEN_W,
  parameter int unsigned CFG_W  = VEC_CFG_W,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned TO_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [CFG_W-1:0]  cmd_cfg,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              op_cfg_vld,
  output logic [CFG_W-1:0]  op_cfg,
  output logic [7:0]        in_data_vld,
  output logic [ADDR_W-1:0] in_data_addr,
  output logic              in_finish,
  input  logic              out_data_vld,
  input  logic              out_finish,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned PIPE_W = ADDR_W + 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [LEN_W-1:0]   len_q, idx_q, idx_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d, cnt_now;
  logic               fin_seen_q, fin_seen_d;
  logic               err_d;
  logic               accept;
  logic               grant;
  logic               issue_last;
  logic               to_sat;

  logic               cmd_rdy_d, busy_d, done_d, op_cfg_vld_d, rd_req_d;
  logic [ADDR_W-1:0]  rd_addr_d;

  logic               pipe_in_vld, pipe_out_vld;
  logic [PIPE_W-1:0]  pipe_in_data, pipe_out_data;

`ifdef VEC_ADD_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;

  assign to_sat = (to_q == '1);

  // Watchdog restarts on every result while draining.
  always_comb begin
    to_d = '0;
    if (state_q == ST_DRAIN && !out_data_vld) to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  logic unused_to_w;
  assign to_sat      = 1'b0;
  assign unused_to_w = ^TO_W;
`endif

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_cnt_d  = out_cnt_q;
    fin_seen_d = fin_seen_q;
    err_d      = err;
    accept     = 1'b0;
    grant      = 1'b0;
    issue_last = 1'b0;
    cnt_now    = out_cnt_q + CNT_W'(out_data_vld);

    unique case (state_q)
      ST_IDLE: begin
        if (out_data_vld) err_d = 1'b1;
        if (cmd_vld) begin
          accept     = 1'b1;
          err_d      = 1'b0;
          idx_d      = '0;
          out_cnt_d  = '0;
          fin_seen_d = 1'b0;
          state_d    = ST_CFG;
        end
      end
      ST_CFG: begin
        out_cnt_d = cnt_now;
        if (out_finish) fin_seen_d = 1'b1;
        state_d = (len_q == '0) ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        out_cnt_d = cnt_now;
        if (out_finish) fin_seen_d = 1'b1;
        if (rd_gnt) begin
          grant = 1'b1;
          idx_d = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            issue_last = 1'b1;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        out_cnt_d = cnt_now;
        if (out_finish) fin_seen_d = 1'b1;
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else if (out_finish || fin_seen_q) begin
          // Finish with a short or long result count still completes, flagged.
          state_d = ST_DONE;
          if (cnt_now != {1'b0, len_q}) err_d = 1'b1;
        end else if (to_sat) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_data_vld) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_rdy_d    = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    op_cfg_vld_d = (state_d == ST_CFG);
    rd_req_d     = (state_d == ST_ISSUE);
    rd_addr_d    = rd_req_d ? (src_q + ADDR_W'(idx_d)) : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command context and progress counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      out_cnt_q  <= '0;
      fin_seen_q <= 1'b0;
    end else begin
      if (accept) begin
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        len_q <= cmd_len;
      end
      idx_q      <= idx_d;
      out_cnt_q  <= out_cnt_d;
      fin_seen_q <= fin_seen_d;
    end
  end

  // Registered outputs; op_cfg doubles as the latched command config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      op_cfg_vld <= 1'b0;
      op_cfg     <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      in_finish  <= 1'b0;
    end else begin
      cmd_rdy    <= cmd_rdy_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      op_cfg_vld <= op_cfg_vld_d;
      if (accept) op_cfg <= cmd_cfg;
      rd_req     <= rd_req_d;
      rd_addr    <= rd_addr_d;
      // Tail entry flagged last means the stream ended the cycle before.
      in_finish  <= pipe_out_vld & pipe_out_data[ADDR_W];
    end
  end

  // Each granted read carries {last, dst+idx}; idle slots carry zeros.
  assign pipe_in_vld  = grant;
  assign pipe_in_data = grant ? {issue_last, dst_q + ADDR_W'(idx_q)} : '0;

  vec_issue_pipe #(
    .DEPTH (RD_LAT),
    .W     (PIPE_W)
  ) u_issue_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (pipe_in_vld),
    .in_data  (pipe_in_data),
    .out_vld  (pipe_out_vld),
    .out_data (pipe_out_data)
  );

  assign in_data_vld  = {8{pipe_out_vld}};
  assign in_data_addr = pipe_out_data[ADDR_W-1:0];

endmodule

// File: tb/tb_vector_adder_ctrl.sv
// Directed bench for vector_adder_ctrl with read/write address scoreboards.
module tb_vector_adder_ctrl;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [12:0] cmd_src, cmd_dst, cmd_len;
  logic [40:0] cmd_cfg;
  logic        rd_req, rd_gnt;
  logic [12:0] rd_addr;
  logic        op_cfg_vld;
  logic [40:0] op_cfg;
  logic [7:0]  in_data_vld;
  logic [12:0] in_data_addr;
  logic        in_finish;
  logic        out_data_vld, out_finish;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_rd[$];
  logic [12:0] exp_wr[$];
  int          exp_vcyc[$];

  always #5 clk = ~clk;

  vector_adder_ctrl #(
    .ADDR_W (13),
    .LEN_W  (13),
    .CFG_W  (41),
    .RD_LAT (RD_LAT),
    .TO_W   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_src      (cmd_src),
    .cmd_dst      (cmd_dst),
    .cmd_len      (cmd_len),
    .cmd_cfg      (cmd_cfg),
    .rd_req       (rd_req),
    .rd_gnt       (rd_gnt),
    .rd_addr      (rd_addr),
    .op_cfg_vld   (op_cfg_vld),
    .op_cfg       (op_cfg),
    .in_data_vld  (in_data_vld),
    .in_data_addr (in_data_addr),
    .in_finish    (in_finish),
    .out_data_vld (out_data_vld),
    .out_finish   (out_finish),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_rdy"},      cmd_rdy, 1);
    check({pfx, "_busy"},         busy, 0);
    check({pfx, "_rd_req"},       rd_req, 0);
    check({pfx, "_rd_addr"},      rd_addr, 0);
    check({pfx, "_op_cfg_vld"},   op_cfg_vld, 0);
    check({pfx, "_op_cfg"},       op_cfg, 0);
    check({pfx, "_in_data_vld"},  in_data_vld, 0);
    check({pfx, "_in_data_addr"}, in_data_addr, 0);
    check({pfx, "_in_finish"},    in_finish, 0);
    check({pfx, "_done"},         done, 0);
    check({pfx, "_err"},          err, 0);
  endtask

  // Drives one command from IDLE to completion, emulating the arbiter and adder.
  task automatic run_cmd(input logic [12:0] src, input logic [12:0] dst,
                         input logic [12:0] len, input logic [40:0] cfg,
                         input bit toggle, input bit drop_last,
                         input bit busy_cmd, input bit exp_err);
    int cyc = 0, req_n = 0, nvld = 0, last_vld = -1, fin_cyc = -1, exp_done;
    bit done_seen = 0, extra = 0;
    exp_rd.delete(); exp_wr.delete(); exp_vcyc.delete();
    for (int i = 0; i < int'(len); i++) begin
      exp_rd.push_back(src + 13'(i));
      exp_wr.push_back(dst + 13'(i));
    end
    check("cmd_rdy_idle", cmd_rdy, 1);
    cmd_vld = 1'b1; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_cfg = cfg;
    while (!done_seen && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (busy_cmd) begin
        cmd_src = ~src; cmd_dst = ~dst; cmd_len = 13'd7; cmd_cfg = ~cfg;
      end else begin
        cmd_vld = 1'b0;
      end
      if (cyc == 1) begin
        check("cfg_vld_c1", op_cfg_vld, 1);
        check("op_cfg_c1", op_cfg, cfg);
        check("busy_c1", busy, 1);
        check("cmd_rdy_c1", cmd_rdy, 0);
        check("err_c1", err, 0);
        check("rd_req_c1", rd_req, 0);
      end else if (op_cfg_vld) begin
        extra = 1;
      end
      if (cyc == 2) check("rd_req_c2", rd_req, len != 0);
      rd_gnt = 1'b0;
      if (rd_req) begin
        if (exp_rd.size() == 0) extra = 1;
        else begin
          check("rd_addr", rd_addr, exp_rd[0]);
          if (!toggle || (req_n % 2) == 0) begin
            rd_gnt = 1'b1;
            void'(exp_rd.pop_front());
            exp_vcyc.push_back(cyc + RD_LAT);
          end
          req_n++;
        end
      end
      out_data_vld = 1'b0; out_finish = 1'b0;
      if (in_data_vld != 8'h00) begin
        check("vld_pattern", in_data_vld, 8'hFF);
        if (exp_wr.size() == 0 || exp_vcyc.size() == 0) extra = 1;
        else begin
          check("in_data_addr", in_data_addr, exp_wr.pop_front());
          check("vld_cycle", cyc, exp_vcyc.pop_front());
        end
        nvld++;
        last_vld = cyc;
        out_data_vld = !(drop_last && nvld == int'(len));
      end
      if (in_finish) begin
        if (fin_cyc >= 0) extra = 1;
        fin_cyc = cyc;
        out_finish = 1'b1;
      end
      if (done) begin
        done_seen = 1;
        exp_done = (len == 0) ? 3 : fin_cyc + 1;
        check("done_cycle", cyc, exp_done);
        check("err_at_done", err, exp_err);
        cmd_vld = 1'b0;
      end
    end
    check("done_seen", done_seen, 1);
    check("extra_events", extra, 0);
    check("rows_in", nvld, int'(len));
    check("rd_left", exp_rd.size(), 0);
    if (len == 0) check("no_finish", fin_cyc, -1);
    else begin
      check("finish_after_last", fin_cyc, last_vld + 1);
      if (!toggle) check("finish_cycle", fin_cyc, int'(len) + RD_LAT + 2);
    end
    @(posedge clk); #1;
    rd_gnt = 1'b0; out_data_vld = 1'b0; out_finish = 1'b0;
    check("cmd_rdy_after", cmd_rdy, 1);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("err_after", err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit stray;
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_cfg = '0;
    rd_gnt = 1'b0; out_data_vld = 1'b0; out_finish = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic stream, full grants.
    run_cmd(13'h010, 13'h100, 13'd4, 41'h1_2345_6789_A, 0, 0, 0, 0);
    // Stalling arbiter while the decoder keeps presenting a different command.
    run_cmd(13'h010, 13'h100, 13'd4, 41'h0_F0F0_F0F0_F, 1, 0, 1, 0);
    // Empty command.
    run_cmd(13'h055, 13'h066, 13'd0, 41'h0_0000_0001_F, 0, 0, 0, 0);
    // Source and destination wrap.
    run_cmd(13'h1FFE, 13'h1FFF, 13'd3, 41'h1_FFFF_0000_0, 0, 0, 0, 0);
    // Short result count flags an error but still completes.
    run_cmd(13'h020, 13'h200, 13'd4, 41'h0_1111_2222_3, 0, 1, 0, 1);
    // Next accepted command clears err.
    run_cmd(13'h0A0, 13'h0B0, 13'd2, 41'h0_ABCD_EF01_2, 1, 0, 0, 0);

    // Stray result while idle.
    out_data_vld = 1'b1;
    @(posedge clk); #1; out_data_vld = 1'b0;
    check("idle_stray_err", err, 1);
    check("idle_stray_busy", busy, 0);

    // Reset during ISSUE with one read in flight.
    cmd_vld = 1'b1; cmd_src = 13'h300; cmd_dst = 13'h400; cmd_len = 13'd6; cmd_cfg = 41'h123;
    @(posedge clk); #1; cmd_vld = 1'b0; rd_gnt = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_rd_req", rd_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; rd_gnt = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (in_data_vld != 8'h00 || in_finish || busy) stray = 1;
    end
    check("post_rst_quiet", stray, 0);
    run_cmd(13'h123, 13'h456, 13'd5, 41'h0_5555_AAAA_5, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_adder_ctrl.md
# vector_adder_ctrl

Sequencer for the vector-adder datapath. Accepts one vector-add command at a time, loads the quant config, and streams operand rows from a shared buffer into the adder. Drives the adder's valid, address and finish strobes, then counts results and reports completion. Sits between the vector-engine command decoder, the buffer read arbiter and the vector_adder instance.

## Interface
Parameters:
- ADDR_W, 13, buffer/result address width
- LEN_W, 13, command length width (rows)
- CFG_W, 41, adder op config width
- RD_LAT, 2, buffer read latency in cycles (>=1)
- TO_W, 8, drain watchdog counter width (timeout build only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  ready for command (high only in IDLE)
- cmd_src  in  ADDR_W  first operand row address
- cmd_dst  in  ADDR_W  first result address
- cmd_len  in  LEN_W  number of rows
- cmd_cfg  in  CFG_W  adder op config
- rd_req  out  1  buffer read request
- rd_gnt  in  1  buffer read grant (same cycle)
- rd_addr  out  ADDR_W  buffer read address
- op_cfg_vld  out  1  adder config load strobe
- op_cfg  out  CFG_W  adder config
- in_data_vld  out  8  adder lane valids (all-ones or zero)
- in_data_addr  out  ADDR_W  result address tag to adder
- in_finish  out  1  end-of-stream pulse to adder
- out_data_vld  in  1  adder result valid
- out_finish  in  1  adder delayed finish
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error, cleared on next command accept

## Operation
- States: IDLE, CFG, ISSUE, DRAIN, DONE.
- IDLE: cmd_rdy=1. On cmd_vld, latch src/dst/len/cfg, clear err and counters, go to CFG.
- CFG: op_cfg_vld=1 for exactly one cycle with the latched cfg. Go to ISSUE, or DRAIN if len==0.
- ISSUE: rd_req=1, rd_addr=src+idx. On each rd_gnt, idx++. A grant when idx==len-1 goes to DRAIN. No grant means hold; the cycle is a stall.
- Issue pipe: RD_LAT-deep shift of {granted, dst+idx}. At the pipe tail, in_data_vld={8{granted}} and in_data_addr=tagged dst. Data comes from the buffer straight into the adder.
- in_finish: one-cycle pulse exactly one cycle after the last in_data_vld. Not asserted when len==0.
- DRAIN: out_cnt counts out_data_vld from CFG onward. Leave when out_finish has been seen and out_cnt==len; for len==0, leave immediately. Go to DONE.
- If out_finish is seen with out_cnt!=len, set err and still go to DONE.
- Extra out_data_vld after DONE or in IDLE sets err.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W, so src+idx and dst+idx wrap silently.
- cmd_vld while busy is ignored; nothing is latched.

## Timing
- Reset values: cmd_rdy=1, busy=0. All other outputs 0; pipe, counters and err cleared.
- Cmd accepted at cycle 0. op_cfg_vld at cycle 1. rd_req first high at cycle 2.
- Grant at cycle g gives in_data_vld at cycle g+RD_LAT.
- With no stalls, len rows take len issue cycles. in_finish fires at cycle 2+len-1+RD_LAT+1.
- done fires one cycle after the DRAIN exit condition. cmd_rdy is high the cycle after done.
- Reset mid-operation aborts immediately: in-flight pipe entries are dropped and no in_finish is emitted.

## Configuration
- VEC_ADD_CTRL_TIMEOUT_EN defined:
  - A TO_W-bit watchdog runs in DRAIN and resets on every out_data_vld.
  - Saturation sets err and forces DONE.
- Undefined:
  - No watchdog. DRAIN waits indefinitely; TO_W is unused.

## Structure
- Shared vector-engine package holds:
  - state enum (IDLE/CFG/ISSUE/DRAIN/DONE);
  - ADDR_W / LEN_W / CFG_W constants;
  - op_cfg field offsets: scale [30:21], bias [20:5], shift [4:0].
- One sub-module: vec_issue_pipe. It is the RD_LAT-deep valid+address delay line, reused by the other vector-engine controllers.

## Test plan
- len=4, src=0x010, dst=0x100, rd_gnt always 1, RD_LAT=2:
  - op_cfg_vld at cycle 1;
  - rd_addr 0x010..0x013 at cycles 2–5;
  - in_data_vld=0xFF at cycles 4–7, in_data_addr 0x100..0x103;
  - in_finish at cycle 8;
  - done one cycle after out_finish + 4th out_data_vld; err=0.
- Same command with rd_gnt toggling 1,0,1,0:
  - rd_addr holds during stalls;
  - in_data_vld gaps mirror the stalls;
  - total of 4 valids; in_finish one cycle after the last valid.
- len=0:
  - op_cfg_vld pulses, then done within 3 cycles;
  - no rd_req, no in_finish, err=0.
- src=0x1FFE, len=3: rd_addr sequence 0x1FFE, 0x1FFF, 0x0000.
- out_finish after only 3 out_data_vld for len=4: err=1 and done pulses. err clears on the next accepted command.
- rst_n low during ISSUE:
  - all outputs return to reset values asynchronously;
  - after release, cmd_rdy=1 and a fresh command runs normally.
  - With VEC_ADD_CTRL_TIMEOUT_EN and no out_finish, err+done appear 2^TO_W−1 cycles into DRAIN.
